// File: rtl/line_memory_responder_pkg.sv
// Shared definitions for the line memory responder slice.
//   LINE_BITS   - width of one cache line (256 bits)
//   ADDR_BITS   - width of the byte address bus (32 bits)
//   OFFSET_BITS - byte-offset bits inside a line, ignored by the responder
//   state_e     - FSM state encoding (IDLE -> WAIT -> ACK)
//   LINE_ONES   - value returned for a read of an out-of-range line
package line_mem_pkg;

  localparam int LINE_BITS   = 256;
  localparam int ADDR_BITS   = 32;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  localparam logic [LINE_BITS-1:0] LINE_ONES = {LINE_BITS{1'b1}};

endpackage

// File: rtl/line_memory_responder_if.sv
// Cache-controller <-> line memory bus.
// Handshake: the master raises mem_enable_i with mem_write_i, mem_addr_i and
// mem_data_i, and holds all of them until it sees mem_ack_o, a single-cycle
// pulse. mem_data_o carries read data in the ack cycle and holds it until the
// next read completes.
//   master modport: drives the request, observes ack/read data
//   slave  modport: the responder side
interface line_mem_if;
  import line_mem_pkg::*;

  logic                 mem_enable_i;
  logic                 mem_write_i;
  logic [ADDR_BITS-1:0] mem_addr_i;
  logic [LINE_BITS-1:0] mem_data_i;
  logic                 mem_ack_o;
  logic [LINE_BITS-1:0] mem_data_o;

  modport master (
    output mem_enable_i, mem_write_i, mem_addr_i, mem_data_i,
    input  mem_ack_o, mem_data_o
  );

  modport slave (
    input  mem_enable_i, mem_write_i, mem_addr_i, mem_data_i,
    output mem_ack_o, mem_data_o
  );
endinterface

// File: rtl/line_memory_responder_array.sv
// Line storage: 2^DEPTH_LOG2 lines of LINE_BITS bits.
// Ports:
//   clk_i   - clock
//   we_i    - write enable, line written at the rising edge
//   waddr_i - write line index
//   wdata_i - write line data
//   raddr_i - read line index (combinational read)
//   rdata_o - read line data
// Contents are not reset.
module line_mem_array
  import line_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [LINE_BITS-1:0]  wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [LINE_BITS-1:0]  rdata_o
);

  logic [LINE_BITS-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/line_memory_responder.sv
// Fixed-latency line memory model answering a cache controller.
// A request accepted in IDLE acks exactly LATENCY cycles later; the array
// write or the read-data register update happens on the edge entering ACK.
// Ports:
//   clk_i   - clock, rising edge
//   rst_i   - synchronous active-high reset (state, counter, outputs; not array)
//   bus     - line_mem_if slave modport (request in, ack/read data out)
//   state_o - current FSM state, for observation
//   err_o   - sticky out-of-range flag, only with LINE_MEM_OOR_CHECK_EN
// Build option: LINE_MEM_OOR_CHECK_EN flags addresses with bits set above the
// indexed range instead of letting them alias, and returns all-ones on read.
module line_memory_responder
  import line_mem_pkg::*;
#(
  parameter int LATENCY    = 10,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic        clk_i,
  input  logic        rst_i,
  line_mem_if.slave   bus,
  output state_e      state_o
`ifdef LINE_MEM_OOR_CHECK_EN
  ,
  output logic        err_o
`endif
);

  localparam int IDX_LO = OFFSET_BITS;
  localparam int IDX_HI = DEPTH_LOG2 + OFFSET_BITS - 1;
  // WAIT runs for cnt = LATENCY-2 down to 0, i.e. LATENCY-1 cycles.
  localparam logic [7:0] CNT_INIT = (LATENCY >= 2) ? 8'(LATENCY - 2) : 8'd0;

  state_e                state_q;
  logic [7:0]            cnt_q;
  logic                  wr_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [LINE_BITS-1:0]  data_q;
  logic                  oor_q;
  logic                  ack_q;
  logic [LINE_BITS-1:0]  rdata_q;
  logic                  err_q;

  logic                  in_oor;
  logic                  accept;
  logic                  go_ack;
  logic                  eff_wr;
  logic [DEPTH_LOG2-1:0] eff_idx;
  logic [LINE_BITS-1:0]  eff_data;
  logic                  eff_oor;
  logic                  arr_we;
  logic [LINE_BITS-1:0]  arr_rdata;

`ifdef LINE_MEM_OOR_CHECK_EN
  assign in_oor = |bus.mem_addr_i[ADDR_BITS-1:IDX_HI+1];
  logic unused_addr;
  assign unused_addr = ^bus.mem_addr_i[OFFSET_BITS-1:0];
`else
  // Upper address bits are ignored so addresses alias into the array.
  assign in_oor = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{bus.mem_addr_i[OFFSET_BITS-1:0],
                         bus.mem_addr_i[ADDR_BITS-1:IDX_HI+1]};
`endif

  assign accept = (state_q == ST_IDLE) && bus.mem_enable_i;
  assign go_ack = (accept && (LATENCY == 1)) ||
                  ((state_q == ST_WAIT) && (cnt_q == 8'd0));

  // With LATENCY=1 the commit edge is the accept edge itself, so the live
  // request fields are used; otherwise the captured copies govern.
  assign eff_wr   = (state_q == ST_IDLE) ? bus.mem_write_i : wr_q;
  assign eff_idx  = (state_q == ST_IDLE) ? bus.mem_addr_i[IDX_HI:IDX_LO] : idx_q;
  assign eff_data = (state_q == ST_IDLE) ? bus.mem_data_i : data_q;
  assign eff_oor  = (state_q == ST_IDLE) ? in_oor : oor_q;

  // Reset suppresses the commit so an aborted write never reaches the array.
  assign arr_we = go_ack && eff_wr && !eff_oor && !rst_i;

  line_mem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (arr_we),
    .waddr_i (eff_idx),
    .wdata_i (eff_data),
    .raddr_i (eff_idx),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      oor_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= go_ack;
      if (go_ack && !eff_wr) begin
        rdata_q <= eff_oor ? LINE_ONES : arr_rdata;
      end
      if (go_ack && eff_oor) begin
        err_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.mem_enable_i) begin
            wr_q    <= bus.mem_write_i;
            idx_q   <= bus.mem_addr_i[IDX_HI:IDX_LO];
            data_q  <= bus.mem_data_i;
            oor_q   <= in_oor;
            cnt_q   <= CNT_INIT;
            state_q <= (LATENCY == 1) ? ST_ACK : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 8'd0) begin
            state_q <= ST_ACK;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_ack_o  = ack_q;
  assign bus.mem_data_o = rdata_q;
  assign state_o        = state_q;

`ifdef LINE_MEM_OOR_CHECK_EN
  assign err_o = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_line_memory_responder.sv
module tb_line_memory_responder;
  import line_mem_pkg::*;

  localparam logic [LINE_BITS-1:0] PAT_A5 = {32{8'hA5}};
  localparam logic [LINE_BITS-1:0] PAT_P1 = {8{32'h1234_5678}};
  localparam logic [LINE_BITS-1:0] PAT_Q0 = {16{16'hBEEF}};
  localparam logic [LINE_BITS-1:0] PAT_Q1 = {16{16'hDEAD}};
  localparam logic [LINE_BITS-1:0] PAT_Z  = {4{64'h0F0F_1E1E_2D2D_3C3C}};
  localparam logic [LINE_BITS-1:0] PAT_D1 = {8{32'hCAFE_F00D}};

  logic clk;
  logic rst;
  state_e st10;
  state_e st1;
  int n_vec;
  int n_err;

  line_mem_if if10 ();
  line_mem_if if1 ();

`ifdef LINE_MEM_OOR_CHECK_EN
  logic err10;
  logic err1;
`endif

  line_memory_responder #(.LATENCY(10), .DEPTH_LOG2(9)) u_dut10 (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (if10),
    .state_o (st10)
`ifdef LINE_MEM_OOR_CHECK_EN
    ,
    .err_o   (err10)
`endif
  );

  line_memory_responder #(.LATENCY(1), .DEPTH_LOG2(9)) u_dut1 (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (if1),
    .state_o (st1)
`ifdef LINE_MEM_OOR_CHECK_EN
    ,
    .err_o   (err1)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    if10.mem_enable_i = 1'b0;
    if1.mem_enable_i  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One LATENCY=10 transaction. lat = cycles from accept edge to the ack
  // cycle (-1 on timeout). With perturb set, addr/data are corrupted mid-WAIT.
  task automatic txn10(input logic wr, input logic [31:0] a,
                       input logic [LINE_BITS-1:0] d, input bit perturb,
                       output int lat);
    lat = -1;
    @(negedge clk);
    if10.mem_enable_i = 1'b1;
    if10.mem_write_i  = wr;
    if10.mem_addr_i   = a;
    if10.mem_data_i   = d;
    @(posedge clk);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (perturb && k == 3) begin
        if10.mem_addr_i = 32'h0000_0040;
        if10.mem_data_i = ~d;
      end
      if (if10.mem_ack_o === 1'b1) begin
        lat = k + 1;
        break;
      end
      @(posedge clk);
    end
    if10.mem_enable_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (if10.mem_ack_o !== 1'b0) begin
      n_err++; $display("FAIL reset_ack10 got %b exp 0", if10.mem_ack_o);
    end
    n_vec++;
    if (if10.mem_data_o !== '0) begin
      n_err++; $display("FAIL reset_data10 got %h exp 0", if10.mem_data_o);
    end
    n_vec++;
    if (st10 !== ST_IDLE) begin
      n_err++; $display("FAIL reset_state10 got %0d exp %0d", st10, ST_IDLE);
    end
    n_vec++;
    if (if1.mem_ack_o !== 1'b0 || if1.mem_data_o !== '0) begin
      n_err++; $display("FAIL reset_l1 got ack %b data %h exp 0/0", if1.mem_ack_o, if1.mem_data_o);
    end
`ifdef LINE_MEM_OOR_CHECK_EN
    n_vec++;
    if (err10 !== 1'b0) begin
      n_err++; $display("FAIL reset_err got %b exp 0", err10);
    end
`endif
  endtask

  task automatic test_write();
    int lat;
    txn10(1'b1, 32'h0000_0040, PAT_A5, 1'b0, lat);
    n_vec++;
    if (lat !== 10) begin
      n_err++; $display("FAIL write_latency got %0d exp 10", lat);
    end
    n_vec++;
    if (if10.mem_data_o !== '0) begin
      n_err++; $display("FAIL write_data_unchanged got %h exp 0", if10.mem_data_o);
    end
    @(negedge clk);
    n_vec++;
    if (if10.mem_ack_o !== 1'b0) begin
      n_err++; $display("FAIL write_ack_width got %b exp 0", if10.mem_ack_o);
    end
  endtask

  task automatic test_read();
    int lat;
    txn10(1'b0, 32'h0000_0040, '0, 1'b0, lat);
    n_vec++;
    if (lat !== 10) begin
      n_err++; $display("FAIL read_latency got %0d exp 10", lat);
    end
    n_vec++;
    if (if10.mem_data_o !== PAT_A5) begin
      n_err++; $display("FAIL read_data got %h exp %h", if10.mem_data_o, PAT_A5);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (if10.mem_data_o !== PAT_A5 || if10.mem_ack_o !== 1'b0) begin
      n_err++; $display("FAIL read_hold got %h ack %b exp %h ack 0", if10.mem_data_o, if10.mem_ack_o, PAT_A5);
    end
  endtask

  task automatic test_capture();
    int lat;
    txn10(1'b1, 32'h0000_0060, PAT_P1, 1'b1, lat);
    n_vec++;
    if (lat !== 10) begin
      n_err++; $display("FAIL capture_latency got %0d exp 10", lat);
    end
    n_vec++;
    if (if10.mem_data_o !== PAT_A5) begin
      n_err++; $display("FAIL capture_rdata_held got %h exp %h", if10.mem_data_o, PAT_A5);
    end
    txn10(1'b0, 32'h0000_0060, '0, 1'b0, lat);
    n_vec++;
    if (if10.mem_data_o !== PAT_P1) begin
      n_err++; $display("FAIL capture_line got %h exp %h", if10.mem_data_o, PAT_P1);
    end
    txn10(1'b0, 32'h0000_0040, '0, 1'b0, lat);
    n_vec++;
    if (if10.mem_data_o !== PAT_A5) begin
      n_err++; $display("FAIL capture_other_line got %h exp %h", if10.mem_data_o, PAT_A5);
    end
  endtask

  task automatic test_back_to_back();
    int first;
    int gap;
    first = -1;
    gap = -1;
    @(negedge clk);
    if1.mem_enable_i = 1'b1;
    if1.mem_write_i  = 1'b1;
    if1.mem_addr_i   = 32'h0000_0080;
    if1.mem_data_i   = PAT_D1;
    @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (if1.mem_ack_o === 1'b1) begin
        first = k + 1;
        break;
      end
      @(posedge clk);
    end
    n_vec++;
    if (first !== 1) begin
      n_err++; $display("FAIL b2b_first_latency got %0d exp 1", first);
    end
    n_vec++;
    if (if1.mem_data_o !== '0) begin
      n_err++; $display("FAIL b2b_write_data_unchanged got %h exp 0", if1.mem_data_o);
    end
    // enable stays high; switch to a read of the same line
    if1.mem_write_i = 1'b0;
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      if (if1.mem_ack_o === 1'b1) begin
        gap = k;
        break;
      end
    end
    if1.mem_enable_i = 1'b0;
    n_vec++;
    if (gap !== 2) begin
      n_err++; $display("FAIL b2b_gap got %0d exp 2", gap);
    end
    n_vec++;
    if (if1.mem_data_o !== PAT_D1) begin
      n_err++; $display("FAIL b2b_read_data got %h exp %h", if1.mem_data_o, PAT_D1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int lat;
    int acks;
    acks = 0;
    txn10(1'b1, 32'h0000_0100, PAT_Q0, 1'b0, lat);
    @(negedge clk);
    if10.mem_enable_i = 1'b1;
    if10.mem_write_i  = 1'b1;
    if10.mem_addr_i   = 32'h0000_0100;
    if10.mem_data_i   = PAT_Q1;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (if10.mem_ack_o === 1'b1) acks++;
      if (k < 4) @(posedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    if10.mem_enable_i = 1'b0;
    n_vec++;
    if (if10.mem_ack_o !== 1'b0 || if10.mem_data_o !== '0 || st10 !== ST_IDLE) begin
      n_err++; $display("FAIL abort_outputs got ack %b data %h state %0d exp 0/0/IDLE",
                        if10.mem_ack_o, if10.mem_data_o, st10);
    end
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (if10.mem_ack_o === 1'b1) acks++;
    end
    n_vec++;
    if (acks !== 0) begin
      n_err++; $display("FAIL abort_no_ack got %0d acks exp 0", acks);
    end
    txn10(1'b0, 32'h0000_0100, '0, 1'b0, lat);
    n_vec++;
    if (if10.mem_data_o !== PAT_Q0) begin
      n_err++; $display("FAIL abort_line_kept got %h exp %h", if10.mem_data_o, PAT_Q0);
    end
  endtask

  task automatic test_oor();
    int lat;
    txn10(1'b1, 32'h0000_0000, PAT_Z, 1'b0, lat);
    txn10(1'b0, 32'h0001_0000, '0, 1'b0, lat);
    n_vec++;
    if (lat !== 10) begin
      n_err++; $display("FAIL oor_latency got %0d exp 10", lat);
    end
`ifdef LINE_MEM_OOR_CHECK_EN
    n_vec++;
    if (if10.mem_data_o !== LINE_ONES) begin
      n_err++; $display("FAIL oor_data got %h exp all-ones", if10.mem_data_o);
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if (err10 !== 1'b1) begin
      n_err++; $display("FAIL oor_err_sticky got %b exp 1", err10);
    end
    txn10(1'b0, 32'h0000_0000, '0, 1'b0, lat);
    n_vec++;
    if (if10.mem_data_o !== PAT_Z) begin
      n_err++; $display("FAIL oor_line0_untouched got %h exp %h", if10.mem_data_o, PAT_Z);
    end
    do_reset();
    n_vec++;
    if (err10 !== 1'b0) begin
      n_err++; $display("FAIL oor_err_cleared got %b exp 0", err10);
    end
`else
    n_vec++;
    if (if10.mem_data_o !== PAT_Z) begin
      n_err++; $display("FAIL oor_alias got %h exp %h", if10.mem_data_o, PAT_Z);
    end
`endif
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    if10.mem_enable_i = 1'b0;
    if10.mem_write_i  = 1'b0;
    if10.mem_addr_i   = '0;
    if10.mem_data_i   = '0;
    if1.mem_enable_i  = 1'b0;
    if1.mem_write_i   = 1'b0;
    if1.mem_addr_i    = '0;
    if1.mem_data_i    = '0;
    test_reset();
    test_write();
    test_read();
    test_capture();
    test_back_to_back();
    test_reset_abort();
    test_oor();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/line_memory_responder.md
LINE_MEMORY_RESPONDER -- requirements
Module: line_memory_responder

Interface
REQ-001 Parameter LATENCY, default 10: cycles from request accept to ack; legal range 1..255.
REQ-002 Parameter DEPTH_LOG2, default 9: log2 of line count (512 lines x 256 bits).
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 mem_enable_i  input  1  request valid; held by the cache controller until ack.
REQ-006 mem_write_i  input  1  1 = line write, 0 = line read; sampled with enable.
REQ-007 mem_addr_i  input  32  byte address; bits [4:0] ignored (line aligned).
REQ-008 mem_data_i  input  256  write line data.
REQ-009 mem_ack_o  output  1  one-cycle completion pulse.
REQ-010 mem_data_o  output  256  read line data; valid in the ack cycle.

Function
REQ-011 FSM states: IDLE, WAIT, ACK.
REQ-012 IDLE: mem_enable_i=1 at a clock edge captures write, address index mem_addr_i[DEPTH_LOG2+4:5] and mem_data_i; next state is ACK if LATENCY=1, otherwise WAIT with counter=LATENCY-2.
REQ-013 WAIT: counter decrements each cycle; at counter=0 the next state is ACK; duration is exactly LATENCY-1 cycles.
REQ-014 The request accepted at the end of cycle N yields mem_ack_o=1 in cycle N+LATENCY, for exactly one cycle.
REQ-015 Input changes after accept are ignored until the FSM returns to IDLE; the captured values govern the transaction.
REQ-016 Write: the array line is updated on the edge entering ACK; mem_data_o keeps its previous value.
REQ-017 Read: mem_data_o is registered on the edge entering ACK and holds until the next read completes.
REQ-018 ACK always returns to IDLE, which can accept a new request the cycle after ack; enable held high there starts a new transaction (back-to-back write-back then allocate).
REQ-019 Address bits above DEPTH_LOG2+4 wrap (are ignored) unless REQ-025 applies.
REQ-020 A read of a never-written line returns the array's current content; no defined init value is required.

Reset
REQ-021 rst_i=1 at an edge forces: state IDLE, counter 0, mem_ack_o 0, mem_data_o 0.
REQ-022 Reset during WAIT or ACK aborts the transaction; a pending write not yet committed is discarded; no ack is issued.
REQ-023 Array contents are not reset.
REQ-024 rst_i has priority over a simultaneous mem_enable_i.

Configuration
REQ-025 Macro LINE_MEM_OOR_CHECK_EN defined: adds output err_o (1 bit, reset 0, sticky until reset); a request with any nonzero mem_addr_i bit above DEPTH_LOG2+4 still acks with normal latency, performs no array access, returns all-ones on read, and sets err_o.
REQ-026 Macro undefined: err_o is absent and out-of-range addresses wrap per REQ-019.

Structure
REQ-027 Package line_mem_pkg holds LINE_BITS=256, ADDR_BITS=32, OFFSET_BITS=5, the FSM state typedef and the 256-bit all-ones OOR sentinel.
REQ-028 Sub-module line_mem_array: 2^DEPTH_LOG2 x 256 storage with a synchronous write port and a combinational read port; the FSM, counter and output registers stay in the top.

Verification
REQ-029 LATENCY=10: write addr 0x0000_0040 with data 0xA5 repeated; the ack appears exactly 10 cycles after the accept edge, is 1 cycle wide, and mem_data_o is unchanged.
REQ-030 Read of 0x0000_0040 after REQ-029 -> ack at +10 with mem_data_o = the 0xA5 pattern, held until the next read.
REQ-031 LATENCY=1: enable held high across the ack with write=1 then write=0 to 0x80 -> acks in consecutive transactions, with the second ack 2 cycles after the first and the read returning the written line.
REQ-032 Change mem_addr_i/mem_data_i during WAIT -> the written line and address equal the values captured at accept.
REQ-033 Assert rst_i at WAIT cycle 5 of a write to 0x100 -> no ack, all outputs 0; a later read of 0x100 returns the pre-write content.
REQ-034 With LINE_MEM_OOR_CHECK_EN: read 0x0001_0000 (DEPTH_LOG2=9) -> ack at +LATENCY with all-ones data and err_o=1 until reset; without the macro, the same address aliases line 0.
